// File: rtl/yc_token_driver_if.sv
// Request/response handshake plus the ternary in/match/out lines between
// synchronous test logic and a ycfsm array edge.
interface yc_token_driver_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_in;
  logic       req_match;
  logic [1:0] vin;
  logic [1:0] vmatch;
  logic [1:0] vout;
  logic       rsp_valid;
  logic       rsp_bit;
  logic       rsp_err;

  modport master (
    output req_valid, req_in, req_match, vout,
    input  req_ready, vin, vmatch, rsp_valid, rsp_bit, rsp_err
  );

  modport slave (
    input  req_valid, req_in, req_match, vout,
    output req_ready, vin, vmatch, rsp_valid, rsp_bit, rsp_err
  );
endinterface

// File: rtl/yc_token_driver.sv
// Clocked four-phase return-to-empty driver for a ycfsm cell's in/match lines,
// with a synchronized sample of the cell's out line and a one-cycle response.
module yc_token_driver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETTLE      = 2,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned TW          = 8
) (
  input logic              clk,
  input logic              reset,
  yc_token_driver_if.slave bus
);

  localparam logic [1:0] VEMPTY = 2'b00;
  localparam logic [1:0] V0     = 2'b01;
  localparam logic [1:0] V1     = 2'b10;
  localparam logic [1:0] VILL   = 2'b11;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] DRV_IN     = 3'd1;
  localparam logic [2:0] WAIT_OUT   = 3'd2;
  localparam logic [2:0] CLR_MATCH  = 3'd3;
  localparam logic [2:0] WAIT_EMPTY = 3'd4;
  localparam logic [2:0] ABORT      = 3'd5;

  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
  localparam logic [TW-1:0] TIMEOUT_C   = TW'(TIMEOUT);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [1:0]    vin_q, vin_d;
  logic [1:0]    vmatch_q, vmatch_d;
  logic          match_q, match_d;
  logic          res_q, res_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_bit_q, rsp_bit_d;
  logic          rsp_err_q, rsp_err_d;
  logic          armed_q;
  logic [1:0]    sync_q [SYNC_STAGES];
  logic [1:0]    vs;
  logic          transfer;
  logic          timed_out;

  function automatic logic [1:0] encode(input logic b);
    return b ? V1 : V0;
  endfunction

  assign vs            = sync_q[SYNC_STAGES-1];
  assign bus.req_ready = armed_q && (state_q == IDLE);
  assign transfer      = bus.req_valid && bus.req_ready;
  assign timed_out     = (cnt_q == TIMEOUT_C);
  assign bus.vin       = vin_q;
  assign bus.vmatch    = vmatch_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_bit   = rsp_bit_q;
  assign bus.rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = timed_out ? cnt_q : cnt_q + TW'(1);
    vin_d       = vin_q;
    vmatch_d    = vmatch_q;
    match_d     = match_q;
    res_d       = res_q;
    rsp_valid_d = 1'b0;
    rsp_bit_d   = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: if (transfer) begin
        match_d = bus.req_match;
        vin_d   = encode(bus.req_in);
        state_d = DRV_IN;
      end
      DRV_IN: if (cnt_q == SETTLE_LAST) begin
        vmatch_d = encode(match_q);
        state_d  = WAIT_OUT;
      end
      WAIT_OUT: begin
        if (vs == VILL) begin
          vin_d    = VEMPTY;
          vmatch_d = VEMPTY;
          state_d  = ABORT;
        end else if (vs != VEMPTY) begin
          res_d    = vs[1];
          vmatch_d = VEMPTY;
          state_d  = CLR_MATCH;
        end else if (timed_out) begin
          // vs is already empty here, so the abort's wait is satisfied at once:
          // clear both lines and respond on the same edge.
          vin_d       = VEMPTY;
          vmatch_d    = VEMPTY;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      CLR_MATCH: if (cnt_q == SETTLE_LAST) begin
        vin_d   = VEMPTY;
        state_d = WAIT_EMPTY;
      end
      WAIT_EMPTY: begin
        if (vs == VEMPTY) begin
          rsp_valid_d = 1'b1;
          rsp_bit_d   = res_q;
          state_d     = IDLE;
        end else if (timed_out) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      ABORT: if (vs == VEMPTY || timed_out) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        vin_d    = VEMPTY;
        vmatch_d = VEMPTY;
        state_d  = IDLE;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vin_q       <= VEMPTY;
      vmatch_q    <= VEMPTY;
      match_q     <= 1'b0;
      res_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_bit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vin_q       <= vin_d;
      vmatch_q    <= vmatch_d;
      match_q     <= match_d;
      res_q       <= res_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bit_q   <= rsp_bit_d;
      rsp_err_q   <= rsp_err_d;
      armed_q     <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= VEMPTY;
    end else begin
      sync_q[0] <= bus.vout;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

endmodule

// File: tb/tb_yc_token_driver.sv
// Directed bench for yc_token_driver driving a behavioural ycfsm cell model.
module tb_yc_token_driver;
  localparam int S = 3;
  localparam int N = 2;
  localparam int T = 40;
  localparam int M_IDEAL = 0;
  localparam int M_ZERO  = 1;
  localparam int M_FORCE = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   rsp_count = 0;
  int   mode = M_FORCE;
  logic [1:0] force_val = 2'b00;
  logic [1:0] d1, d2, d3;

  yc_token_driver_if bus ();

  yc_token_driver #(.SYNC_STAGES(N), .SETTLE(S), .TIMEOUT(T), .TW(6)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Cell: out follows match while in is non-empty, holds when match empties, empties with in.
  function automatic logic [1:0] cell_f(input logic [1:0] vi, input logic [1:0] vm, input logic [1:0] prev);
    if (vi == 2'b00) return 2'b00;
    if (vm != 2'b00) return vm;
    return prev;
  endfunction

  always @(posedge clk) begin
    d1 <= cell_f(bus.vin, bus.vmatch, d1);
    d2 <= d1;
    d3 <= d2;
  end

  assign bus.vout = (mode == M_IDEAL) ? d3 :
                    (mode == M_ZERO)  ? cell_f(bus.vin, bus.vmatch, d1) : force_val;

  always @(negedge clk) if (bus.rsp_valid) rsp_count++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_accept(input logic bi, input logic bm, input bit hold, output bit ok);
    bus.req_in = bi; bus.req_match = bm; bus.req_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin @(posedge clk); #1; end
    if (!hold) bus.req_valid = 1'b0;
  endtask

  // sel 0: vmatch non-empty, 1: rsp_valid, 2: vin empty. n = edges waited, -1 if never.
  task automatic wait_edge(input int sel, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if ((sel == 0 && bus.vmatch != 2'b00) || (sel == 1 && bus.rsp_valid) ||
          (sel == 2 && bus.vin == 2'b00)) begin n = i; break; end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk); #1;
    checks++; if (bus.vin !== 2'b00) begin errors++; $display("FAIL rst_vin got %b want 00", bus.vin); end
    checks++; if (bus.vmatch !== 2'b00) begin errors++; $display("FAIL rst_vmatch got %b want 00", bus.vmatch); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b want 0", bus.rsp_err); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", bus.req_ready); end
    #2 reset = 1'b0; #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_release got %b want 0", bus.req_ready); end
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_edge got %b want 1", bus.req_ready); end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_in1_match1;
    bit ok; int n; int base;
    mode = M_IDEAL; base = rsp_count;
    do_accept(1'b1, 1'b1, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t1_accept got %b want 1", ok); end
    checks++; if (bus.vin !== 2'b10) begin errors++; $display("FAIL t1_vin got %b want 10", bus.vin); end
    checks++; if (bus.vmatch !== 2'b00) begin errors++; $display("FAIL t1_vmatch_early got %b want 00", bus.vmatch); end
    wait_edge(0, 20, n);
    checks++; if (n != S) begin errors++; $display("FAIL t1_settle got %0d want %0d", n, S); end
    checks++; if (bus.vmatch !== 2'b10) begin errors++; $display("FAIL t1_vmatch got %b want 10", bus.vmatch); end
    wait_edge(1, 100, n);
    checks++; if (n < 0) begin errors++; $display("FAIL t1_rsp got none want pulse"); end
    checks++; if (bus.rsp_bit !== 1'b1) begin errors++; $display("FAIL t1_rsp_bit got %b want 1", bus.rsp_bit); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL t1_rsp_err got %b want 0", bus.rsp_err); end
    checks++; if ({bus.vin, bus.vmatch} !== 4'b0000) begin errors++; $display("FAIL t1_lines got %b want 0000", {bus.vin, bus.vmatch}); end
    @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL t1_pulse got %b want 0", bus.rsp_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL t1_idle got %b want 1", bus.req_ready); end
    checks++; if (rsp_count != base + 1) begin errors++; $display("FAIL t1_count got %0d want %0d", rsp_count - base, 1); end
  endtask

  task automatic test_back_to_back;
    bit ok; bit ready_seen; int n; int base; logic [1:0] vm_seen;
    mode = M_IDEAL; base = rsp_count; ready_seen = 1'b0; vm_seen = 2'b00; n = -1;
    do_accept(1'b1, 1'b0, 1'b1, ok);
    checks++; if (bus.vin !== 2'b10) begin errors++; $display("FAIL t2_vin got %b want 10", bus.vin); end
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.vmatch != 2'b00) vm_seen = bus.vmatch;
      if (bus.rsp_valid) begin n = i; break; end
      if (bus.req_ready) ready_seen = 1'b1;
    end
    checks++; if (vm_seen !== 2'b01) begin errors++; $display("FAIL t2_vmatch got %b want 01", vm_seen); end
    checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL t2_ready_busy got %b want 0", ready_seen); end
    checks++; if (n < 0) begin errors++; $display("FAIL t2_rsp got none want pulse"); end
    checks++; if ({bus.rsp_bit, bus.rsp_err} !== 2'b00) begin errors++; $display("FAIL t2_rsp got bit/err %b want 00", {bus.rsp_bit, bus.rsp_err}); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL t2_ready_after got %b want 1", bus.req_ready); end
    bus.req_in = 1'b0; bus.req_match = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++; if (bus.vin !== 2'b01) begin errors++; $display("FAIL t2_second_vin got %b want 01", bus.vin); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL t2_second_ready got %b want 0", bus.req_ready); end
    wait_edge(1, 100, n);
    checks++; if ({bus.rsp_valid, bus.rsp_bit, bus.rsp_err} !== 3'b110) begin errors++; $display("FAIL t2_second_rsp got %b want 110", {bus.rsp_valid, bus.rsp_bit, bus.rsp_err}); end
    @(posedge clk); #1;
    checks++; if (rsp_count != base + 2) begin errors++; $display("FAIL t2_count got %0d want 2", rsp_count - base); end
  endtask

  task automatic test_latency;
    bit ok; int n;
    mode = M_ZERO;
    do_accept(1'b1, 1'b1, 1'b0, ok);
    wait_edge(1, 100, n);
    // accept cycle plus 2S+2N+2 further cycles = 2S+2N+3
    checks++; if (n != 2*S + 2*N + 2) begin errors++; $display("FAIL lat_edges got %0d want %0d", n, 2*S + 2*N + 2); end
    checks++; if ({bus.rsp_bit, bus.rsp_err} !== 2'b10) begin errors++; $display("FAIL lat_rsp got %b want 10", {bus.rsp_bit, bus.rsp_err}); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    bit ok; int n;
    mode = M_FORCE; force_val = 2'b00;
    do_accept(1'b1, 1'b0, 1'b0, ok);
    wait_edge(0, 20, n);
    checks++; if (n != S) begin errors++; $display("FAIL to_wait_entry got %0d want %0d", n, S); end
    wait_edge(1, T + 10, n);
    checks++; if (n != T + 1) begin errors++; $display("FAIL to_edges got %0d want %0d", n, T + 1); end
    checks++; if ({bus.rsp_bit, bus.rsp_err} !== 2'b01) begin errors++; $display("FAIL to_rsp got %b want 01", {bus.rsp_bit, bus.rsp_err}); end
    checks++; if ({bus.vin, bus.vmatch} !== 4'b0000) begin errors++; $display("FAIL to_lines got %b want 0000", {bus.vin, bus.vmatch}); end
    @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL to_pulse got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_illegal;
    bit ok; int n; int base;
    mode = M_FORCE; force_val = 2'b00;
    do_accept(1'b0, 1'b1, 1'b0, ok);
    checks++; if (bus.vin !== 2'b01) begin errors++; $display("FAIL ill_vin got %b want 01", bus.vin); end
    wait_edge(0, 20, n);
    force_val = 2'b11;
    wait_edge(2, 10, n);
    checks++; if (n != N + 1) begin errors++; $display("FAIL ill_clear_edges got %0d want %0d", n, N + 1); end
    checks++; if (bus.vmatch !== 2'b00) begin errors++; $display("FAIL ill_vmatch got %b want 00", bus.vmatch); end
    base = rsp_count;
    repeat (5) @(posedge clk); #1;
    checks++; if (rsp_count != base) begin errors++; $display("FAIL ill_early_rsp got %0d want 0", rsp_count - base); end
    force_val = 2'b00;
    wait_edge(1, 10, n);
    checks++; if (n != N + 1) begin errors++; $display("FAIL ill_rsp_edges got %0d want %0d", n, N + 1); end
    checks++; if ({bus.rsp_bit, bus.rsp_err} !== 2'b01) begin errors++; $display("FAIL ill_rsp got %b want 01", {bus.rsp_bit, bus.rsp_err}); end
    @(posedge clk); #1;
  endtask

  task automatic test_stuck_v1;
    bit ok; int n;
    mode = M_FORCE; force_val = 2'b00;
    do_accept(1'b1, 1'b1, 1'b0, ok);
    wait_edge(0, 20, n);
    force_val = 2'b10;
    wait_edge(2, 30, n);
    checks++; if (n < 0) begin errors++; $display("FAIL stuck_vin_clear got none want vin empty"); end
    wait_edge(1, T + 10, n);
    checks++; if (n != T + 1) begin errors++; $display("FAIL stuck_edges got %0d want %0d", n, T + 1); end
    checks++; if ({bus.rsp_bit, bus.rsp_err} !== 2'b01) begin errors++; $display("FAIL stuck_rsp got %b want 01", {bus.rsp_bit, bus.rsp_err}); end
    force_val = 2'b00;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    bit ok; int n; int base;
    mode = M_FORCE; force_val = 2'b00;
    do_accept(1'b1, 1'b1, 1'b0, ok);
    wait_edge(0, 20, n);
    repeat (2) @(posedge clk); #1;
    base = rsp_count;
    #2 reset = 1'b1; #1;
    checks++; if ({bus.vin, bus.vmatch} !== 4'b0000) begin errors++; $display("FAIL rm_lines got %b want 0000", {bus.vin, bus.vmatch}); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rm_ready got %b want 0", bus.req_ready); end
    @(posedge clk); #2 reset = 1'b0; #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_release got %b want 0", bus.req_ready); end
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_edge got %b want 1", bus.req_ready); end
    repeat (5) @(posedge clk); #1;
    checks++; if (rsp_count != base) begin errors++; $display("FAIL rm_no_rsp got %0d want 0", rsp_count - base); end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_in = 1'b0; bus.req_match = 1'b0;
    test_reset;
    test_in1_match1;
    test_back_to_back;
    test_latency;
    test_timeout;
    test_illegal;
    test_stuck_v1;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
